// File: rtl/comparator_n_bit.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_n_bit
//  Description : Registered WIDTH-bit magnitude comparator producing one-hot
//                equal / greater / lesser flags one cycle after a valid
//                operand pair. Unsigned or two's-complement via SIGNED.
//                Optional min/max outputs when COMPARATOR_MINMAX_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_n_bit #(
  parameter int WIDTH  = 5,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             in_valid,
`ifdef COMPARATOR_MINMAX_EN
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
`endif
  output logic             equal,
  output logic             greater,
  output logic             lesser,
  output logic             out_valid
);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes with no overflow cases.
  localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_SIGN_MASK = (SIGNED != 0) ? (c_ONE << (WIDTH-1)) : '0;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;

  logic             r_equal;
  logic             r_greater;
  logic             r_lesser;
  logic             r_valid;

  assign w_a  = in_1 ^ c_SIGN_MASK;
  assign w_b  = in_2 ^ c_SIGN_MASK;
  assign w_eq = (w_a == w_b);
  assign w_gt = (w_a >  w_b);
  assign w_lt = (w_a <  w_b);

  // Flag register: capture the compare on accepted pairs, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_equal   <= 1'b0;
      r_greater <= 1'b0;
      r_lesser  <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_equal   <= w_eq;
        r_greater <= w_gt;
        r_lesser  <= w_lt;
      end
    end
  end

  assign equal     = r_equal;
  assign greater   = r_greater;
  assign lesser    = r_lesser;
  assign out_valid = r_valid;

`ifdef COMPARATOR_MINMAX_EN
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;

  // Min/max register: on equality both take in_1, updated alongside the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (in_valid) begin
      r_min <= w_gt ? in_2 : in_1;
      r_max <= w_lt ? in_2 : in_1;
    end
  end

  assign min_out = r_min;
  assign max_out = r_max;
`else
  // Min/max datapath not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparator_n_bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_n_bit
//  Description : Directed self-checking bench for comparator_n_bit. Runs an
//                unsigned and a signed instance side by side on shared
//                stimulus. Min/max outputs are checked when
//                COMPARATOR_MINMAX_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_n_bit;

  localparam int WIDTH = 5;

  // {out_valid, equal, greater, lesser}
  localparam logic [3:0] c_E   = 4'b1100;
  localparam logic [3:0] c_G   = 4'b1010;
  localparam logic [3:0] c_L   = 4'b1001;
  localparam logic [3:0] c_HG  = 4'b0010;
  localparam logic [3:0] c_HL  = 4'b0001;
  localparam logic [3:0] c_RST = 4'b0000;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             in_valid;

  logic             eq_u, gt_u, lt_u, ov_u;
  logic             eq_s, gt_s, lt_s, ov_s;
  logic [3:0]       w_flags_u;
  logic [3:0]       w_flags_s;

  int               n_checks;
  int               n_fail;

`ifdef COMPARATOR_MINMAX_EN
  logic [WIDTH-1:0] min_u, max_u, min_s, max_s;
`endif

  comparator_n_bit #(.WIDTH(WIDTH), .SIGNED(0)) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_1      (in_1),
    .in_2      (in_2),
    .in_valid  (in_valid),
`ifdef COMPARATOR_MINMAX_EN
    .min_out   (min_u),
    .max_out   (max_u),
`endif
    .equal     (eq_u),
    .greater   (gt_u),
    .lesser    (lt_u),
    .out_valid (ov_u)
  );

  comparator_n_bit #(.WIDTH(WIDTH), .SIGNED(1)) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_1      (in_1),
    .in_2      (in_2),
    .in_valid  (in_valid),
`ifdef COMPARATOR_MINMAX_EN
    .min_out   (min_s),
    .max_out   (max_s),
`endif
    .equal     (eq_s),
    .greater   (gt_s),
    .lesser    (lt_s),
    .out_valid (ov_s)
  );

  assign w_flags_u = {ov_u, eq_u, gt_u, lt_u};
  assign w_flags_s = {ov_s, eq_s, gt_s, lt_s};

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check #1 after the
  // next rising edge. mn/mx are the expected unsigned-instance min/max.
  task automatic apply(input string tag, input int a, input int b, input logic v,
                       input logic [3:0] exp_u, input logic [3:0] exp_s,
                       input int mn, input int mx);
    @(negedge clk);
    in_1     = WIDTH'(a);
    in_2     = WIDTH'(b);
    in_valid = v;
    @(posedge clk);
    #1;
    chk({tag, "_u"}, 32'(w_flags_u), 32'(exp_u));
    chk({tag, "_s"}, 32'(w_flags_s), 32'(exp_s));
`ifdef COMPARATOR_MINMAX_EN
    chk({tag, "_min"}, 32'(min_u), 32'(mn));
    chk({tag, "_max"}, 32'(max_u), 32'(mx));
`else
    if (mn < 0 || mx < 0) $display("note: negative min/max expectation in %s", tag);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_1     = '0;
    in_2     = '0;
    in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u", 32'(w_flags_u), 32'(c_RST));
    chk("reset_s", 32'(w_flags_s), 32'(c_RST));

    // Get a result in flight, then reset asynchronously mid-cycle
    @(negedge clk);
    rst_n = 1'b1;
    apply("pre_rst", 3, 1, 1'b1, c_G, c_G, 1, 3);
    @(negedge clk);
    in_1 = 5'd1; in_2 = 5'd3; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_u", 32'(w_flags_u), 32'(c_RST));
    chk("async_rst_s", 32'(w_flags_s), 32'(c_RST));
`ifdef COMPARATOR_MINMAX_EN
    chk("async_rst_min", 32'(min_u), 32'd0);
    chk("async_rst_max", 32'(max_u), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("rst_held_u", 32'(w_flags_u), 32'(c_RST));

    // Release with (0,0) valid -> equal next cycle
    @(negedge clk);
    rst_n = 1'b1;
    apply("release", 0, 0, 1'b1, c_E, c_E, 0, 0);

    // Back-to-back sequence; second column is the signed view
    apply("v_2_25",  2, 25, 1'b1, c_L,  c_G,  2, 25);
    apply("v_6_18",  6, 18, 1'b1, c_L,  c_G,  6, 18);
    apply("v_31_16", 31, 16, 1'b1, c_G, c_G, 16, 31);
    apply("hold",    0, 31, 1'b0, c_HG, c_HG, 16, 31);
    apply("v_9_9",   9,  9, 1'b1, c_E,  c_E,  9,  9);
    apply("v_1_7",   1,  7, 1'b1, c_L,  c_L,  1,  7);
    apply("v_16_15", 16, 15, 1'b1, c_G, c_L, 15, 16);
    apply("v_0_31",  0, 31, 1'b1, c_L,  c_G,  0, 31);
    apply("v_31_31", 31, 31, 1'b1, c_E, c_E, 31, 31);
    apply("v_0_0",   0,  0, 1'b1, c_E,  c_E,  0,  0);
    apply("v_15_16", 15, 16, 1'b1, c_L, c_G, 15, 16);

    // Unknown operands while idle must not disturb held results
    @(negedge clk);
    in_1     = 'x;
    in_2     = 'x;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("x_hold_u", 32'(w_flags_u), 32'(c_HL));
    chk("x_hold_s", 32'(w_flags_s), 32'(c_HG));
`ifdef COMPARATOR_MINMAX_EN
    chk("x_hold_min", 32'(min_u), 32'd15);
    chk("x_hold_max", 32'(max_u), 32'd16);
    chk("x_hold_smin", 32'(min_s), 32'd16);
    chk("x_hold_smax", 32'(max_s), 32'd15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
